// File: rtl/ramb_asym_dp_sc_if.sv
// ramb_asym_dp_sc_if: port A/B access signals and collision status of ramb_asym_dp_sc
interface ramb_asym_dp_sc_if #(
  parameter int WIDTH_A  = 1,
  parameter int WIDTH_B  = 8,
  parameter int MEM_BITS = 16384
);
  localparam int ADDR_WIDTH_A = $clog2(MEM_BITS / WIDTH_A);
  localparam int ADDR_WIDTH_B = $clog2(MEM_BITS / WIDTH_B);
  logic [ADDR_WIDTH_A-1:0] addra;
  logic [WIDTH_A-1:0]      dia;
  logic [WIDTH_A-1:0]      doa;
  logic                    ena;
  logic                    wea;
  logic                    ssra;
  logic                    regcea;
  logic [ADDR_WIDTH_B-1:0] addrb;
  logic [WIDTH_B-1:0]      dib;
  logic [WIDTH_B-1:0]      dob;
  logic                    enb;
  logic                    web;
  logic                    ssrb;
  logic                    regceb;
  logic                    coll_clr;
  logic [1:0]              coll;
  modport master (
    output addra, dia, ena, wea, ssra, regcea,
    output addrb, dib, enb, web, ssrb, regceb, coll_clr,
    input  doa, dob, coll
  );
  modport slave (
    input  addra, dia, ena, wea, ssra, regcea,
    input  addrb, dib, enb, web, ssrb, regceb, coll_clr,
    output doa, dob, coll
  );
endinterface

// File: rtl/ramb_asym_dp_sc.sv
// ramb_asym_dp_sc: single-clock true-dual-port RAM with asymmetric port widths over one bit array,
// optional per-port output register and sticky cross-port collision flags.
module ramb_asym_dp_sc #(
  parameter int                 WIDTH_A      = 1,
  parameter int                 WIDTH_B      = 8,
  parameter int                 MEM_BITS     = 16384,
  parameter string              WRITE_MODE_A = "WRITE_FIRST",
  parameter string              WRITE_MODE_B = "WRITE_FIRST",
  parameter logic [WIDTH_A-1:0] INIT_A       = '0,
  parameter logic [WIDTH_B-1:0] INIT_B       = '0,
  parameter logic [WIDTH_A-1:0] SRVAL_A      = '0,
  parameter logic [WIDTH_B-1:0] SRVAL_B      = '0,
  parameter bit                 DO_REG_A     = 1'b0,
  parameter bit                 DO_REG_B     = 1'b0,
  parameter string              INIT_FILE    = ""
) (
  input logic              i_clk,
  input logic              i_rst_n,
  ramb_asym_dp_sc_if.slave io_bus
);
  function automatic bit pow2(input int v);
    return v > 0 && (v & (v - 1)) == 0;
  endfunction
  localparam int RATIO   = WIDTH_B / WIDTH_A;
  localparam int RL      = $clog2(RATIO);
  localparam int DEPTH_A = MEM_BITS / WIDTH_A;
  localparam int AWA     = $clog2(DEPTH_A);
  localparam bit WF_A    = WRITE_MODE_A == "WRITE_FIRST";
  localparam bit RF_A    = WRITE_MODE_A == "READ_FIRST";
  localparam bit NC_A    = WRITE_MODE_A == "NO_CHANGE";
  localparam bit WF_B    = WRITE_MODE_B == "WRITE_FIRST";
  localparam bit RF_B    = WRITE_MODE_B == "READ_FIRST";
  localparam bit NC_B    = WRITE_MODE_B == "NO_CHANGE";
  if (!pow2(WIDTH_A) || !pow2(WIDTH_B) || !pow2(MEM_BITS) || WIDTH_B % WIDTH_A != 0 || WIDTH_B > MEM_BITS) begin : g_geom_err
    $error("ramb_asym_dp_sc: illegal geometry WIDTH_A=%0d WIDTH_B=%0d MEM_BITS=%0d", WIDTH_A, WIDTH_B, MEM_BITS);
  end
  if (!(WF_A || RF_A || NC_A) || !(WF_B || RF_B || NC_B)) begin : g_mode_err
    $error("ramb_asym_dp_sc: unknown write mode A=%s B=%s", WRITE_MODE_A, WRITE_MODE_B);
  end
  // Array is stored as port-A words; a port-B word spans RATIO consecutive A words, lowest in the LSB.
  logic [WIDTH_A-1:0] r_mem [DEPTH_A];
  logic               w_ok_a;
  logic               w_ok_b;
  logic               w_wr_a;
  logic               w_wr_b;
  logic               w_ovl;
  logic [AWA-1:0]     w_base_b;
  logic [WIDTH_A-1:0] w_rd_a;
  logic [WIDTH_B-1:0] w_rd_b;
  logic [WIDTH_A-1:0] w_nxt_a;
  logic [WIDTH_B-1:0] w_nxt_b;
  logic [WIDTH_A-1:0] r_lat_a;
  logic [WIDTH_A-1:0] r_out_a;
  logic [WIDTH_B-1:0] r_lat_b;
  logic [WIDTH_B-1:0] r_out_b;
  logic [1:0]         r_coll;
  assign w_ok_a   = !$isunknown(io_bus.addra);
  assign w_ok_b   = !$isunknown(io_bus.addrb);
  assign w_wr_a   = io_bus.ena && io_bus.wea && w_ok_a;
  assign w_wr_b   = io_bus.enb && io_bus.web && w_ok_b;
  assign w_base_b = AWA'(io_bus.addrb) << RL;
  assign w_ovl    = io_bus.ena && io_bus.enb && w_ok_a && w_ok_b && (io_bus.addra[AWA-1:RL] == io_bus.addrb);
  assign w_rd_a   = r_mem[io_bus.addra];
  always_comb begin
    w_rd_b = '0;
    for (int i = 0; i < RATIO; i++) w_rd_b[i*WIDTH_A +: WIDTH_A] = r_mem[w_base_b + AWA'(i)];
  end
  // Latch stage: SSR only overrides it when there is no output register behind it.
  assign w_nxt_a = !io_bus.ena ? r_lat_a :
                   (!DO_REG_A && io_bus.ssra) ? SRVAL_A :
                   !w_ok_a ? 'x :
                   !io_bus.wea ? w_rd_a :
                   WF_A ? io_bus.dia :
                   RF_A ? w_rd_a : r_lat_a;
  assign w_nxt_b = !io_bus.enb ? r_lat_b :
                   (!DO_REG_B && io_bus.ssrb) ? SRVAL_B :
                   !w_ok_b ? 'x :
                   !io_bus.web ? w_rd_b :
                   WF_B ? io_bus.dib :
                   RF_B ? w_rd_b : r_lat_b;
  // Port B is written last so it wins every overlapping bit on a write-write collision.
  always_ff @(posedge i_clk) begin
    if (w_wr_a) r_mem[io_bus.addra] <= io_bus.dia;
    if (w_wr_b) for (int i = 0; i < RATIO; i++) r_mem[w_base_b + AWA'(i)] <= io_bus.dib[i*WIDTH_A +: WIDTH_A];
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lat_a <= INIT_A;
      r_out_a <= INIT_A;
      r_lat_b <= INIT_B;
      r_out_b <= INIT_B;
      r_coll  <= 2'b00;
    end else begin
      r_lat_a <= w_nxt_a;
      r_lat_b <= w_nxt_b;
      if (DO_REG_A && io_bus.regcea) r_out_a <= io_bus.ssra ? SRVAL_A : r_lat_a;
      if (DO_REG_B && io_bus.regceb) r_out_b <= io_bus.ssrb ? SRVAL_B : r_lat_b;
      r_coll <= (io_bus.coll_clr ? 2'b00 : r_coll) |
                {w_ovl && (io_bus.wea != io_bus.web), w_ovl && io_bus.wea && io_bus.web};
    end
  end
  assign io_bus.doa  = DO_REG_A ? r_out_a : r_lat_a;
  assign io_bus.dob  = DO_REG_B ? r_out_b : r_lat_b;
  assign io_bus.coll = r_coll;
endmodule

// File: tb/tb_ramb_asym_dp_sc.sv
// tb_ramb_asym_dp_sc: three differently configured RAMs on shared stimulus, checked against a
// behavioural bit-array model every cycle plus literal expectations for the key scenarios.
module tb_ramb_asym_dp_sc;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [13:0] addra;
  logic [10:0] addrb;
  logic        dia, ena, wea, ssra, regcea;
  logic [7:0]  dib;
  logic        enb, web, ssrb, regceb, coll_clr;
  int n_chk = 0;
  int n_fail = 0;
  localparam int MA  [3] = '{0, 1, 2};
  localparam int MB  [3] = '{0, 2, 1};
  localparam int DRA [3] = '{0, 0, 1};
  localparam int DRB [3] = '{0, 1, 0};
  localparam int IA  [3] = '{1, 0, 1};
  localparam int IB  [3] = '{'h5A, 'hC3, 'h00};
  localparam int SA  [3] = '{1, 1, 0};
  localparam int SB  [3] = '{'h81, 'h81, 'h7E};
  ramb_asym_dp_sc_if #(.WIDTH_A(1), .WIDTH_B(8), .MEM_BITS(16384)) b0 ();
  ramb_asym_dp_sc_if #(.WIDTH_A(1), .WIDTH_B(8), .MEM_BITS(16384)) b1 ();
  ramb_asym_dp_sc_if #(.WIDTH_A(1), .WIDTH_B(8), .MEM_BITS(16384)) b2 ();
  assign {b0.addra, b0.dia, b0.ena, b0.wea, b0.ssra, b0.regcea, b0.addrb, b0.dib, b0.enb, b0.web, b0.ssrb, b0.regceb, b0.coll_clr} =
         {addra, dia, ena, wea, ssra, regcea, addrb, dib, enb, web, ssrb, regceb, coll_clr};
  assign {b1.addra, b1.dia, b1.ena, b1.wea, b1.ssra, b1.regcea, b1.addrb, b1.dib, b1.enb, b1.web, b1.ssrb, b1.regceb, b1.coll_clr} =
         {addra, dia, ena, wea, ssra, regcea, addrb, dib, enb, web, ssrb, regceb, coll_clr};
  assign {b2.addra, b2.dia, b2.ena, b2.wea, b2.ssra, b2.regcea, b2.addrb, b2.dib, b2.enb, b2.web, b2.ssrb, b2.regceb, b2.coll_clr} =
         {addra, dia, ena, wea, ssra, regcea, addrb, dib, enb, web, ssrb, regceb, coll_clr};
  ramb_asym_dp_sc #(.WIDTH_A(1), .WIDTH_B(8), .MEM_BITS(16384), .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("WRITE_FIRST"),
    .INIT_A(1'b1), .INIT_B(8'h5A), .SRVAL_A(1'b1), .SRVAL_B(8'h81), .DO_REG_A(1'b0), .DO_REG_B(1'b0))
    u0 (.i_clk(clk), .i_rst_n(rst_n), .io_bus(b0));
  ramb_asym_dp_sc #(.WIDTH_A(1), .WIDTH_B(8), .MEM_BITS(16384), .WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("NO_CHANGE"),
    .INIT_A(1'b0), .INIT_B(8'hC3), .SRVAL_A(1'b1), .SRVAL_B(8'h81), .DO_REG_A(1'b0), .DO_REG_B(1'b1))
    u1 (.i_clk(clk), .i_rst_n(rst_n), .io_bus(b1));
  ramb_asym_dp_sc #(.WIDTH_A(1), .WIDTH_B(8), .MEM_BITS(16384), .WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("READ_FIRST"),
    .INIT_A(1'b1), .INIT_B(8'h00), .SRVAL_A(1'b0), .SRVAL_B(8'h7E), .DO_REG_A(1'b1), .DO_REG_B(1'b0))
    u2 (.i_clk(clk), .i_rst_n(rst_n), .io_bus(b2));
  logic       doa_v  [3];
  logic [7:0] dob_v  [3];
  logic [1:0] coll_v [3];
  assign doa_v[0] = b0.doa;
  assign doa_v[1] = b1.doa;
  assign doa_v[2] = b2.doa;
  assign dob_v[0] = b0.dob;
  assign dob_v[1] = b1.dob;
  assign dob_v[2] = b2.dob;
  assign coll_v[0] = b0.coll;
  assign coll_v[1] = b1.coll;
  assign coll_v[2] = b2.coll;
  // Reference: flat bit array plus, per instance, the value each port's stages should hold.
  logic [16383:0] mm;
  logic           la [3];
  logic           oa [3];
  logic [7:0]     lb [3];
  logic [7:0]     ob [3];
  logic [1:0]     mc;
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [7:0] seen(input int mode, input logic we, input logic [7:0] wd, input logic [7:0] old, input logic [7:0] prev);
    if (!we) return old;
    return mode == 0 ? wd : mode == 1 ? old : prev;
  endfunction
  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      la[i] = 1'(IA[i]);
      oa[i] = 1'(IA[i]);
      lb[i] = 8'(IB[i]);
      ob[i] = 8'(IB[i]);
    end
    mc = 2'b00;
  endtask
  task automatic model_step();
    int ia, ib;
    logic ov, ra;
    logic [7:0] rb;
    ia = int'(addra);
    ib = int'(addrb);
    ov = ena && enb && (ia / 8 == ib);
    ra = mm[ia];
    rb = mm[ib*8 +: 8];
    for (int i = 0; i < 3; i++) begin
      if (DRA[i] != 0 && regcea) oa[i] = ssra ? 1'(SA[i]) : la[i];
      if (DRB[i] != 0 && regceb) ob[i] = ssrb ? 8'(SB[i]) : lb[i];
      if (ena) la[i] = (DRA[i] == 0 && ssra) ? 1'(SA[i]) : 1'(seen(MA[i], wea, 8'(dia), 8'(ra), 8'(la[i])));
      if (enb) lb[i] = (DRB[i] == 0 && ssrb) ? 8'(SB[i]) : seen(MB[i], web, dib, rb, lb[i]);
    end
    if (ena && wea) mm[ia] = dia;
    if (enb && web) mm[ib*8 +: 8] = dib;
    mc = (coll_clr ? 2'b00 : mc) | {ov && (wea != web), ov && wea && web};
  endtask
  task automatic idle();
    {ena, wea, ssra, enb, web, ssrb, coll_clr} = '0;
    {regcea, regceb} = 2'b11;
  endtask
  task automatic tick();
    if (rst_n) model_step();
    @(negedge clk);
  endtask
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model doa[%0d]", i), 8'(doa_v[i]), 8'(DRA[i] != 0 ? oa[i] : la[i]));
      chk($sformatf("model dob[%0d]", i), dob_v[i], DRB[i] != 0 ? ob[i] : lb[i]);
      chk($sformatf("model coll[%0d]", i), 8'(coll_v[i]), 8'(mc));
    end
  end
  initial begin
    logic [7:0] pat;
    pat = 8'hA5;
    addra = '0;
    addrb = '0;
    dia = 1'b0;
    dib = '0;
    idle();
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset doa", 8'(doa_v[0]), 8'h01);
    chk("reset dob", dob_v[0], 8'h5A);
    chk("reset coll", 8'(coll_v[0]), 8'h00);
    rst_n = 1'b1;
    tick();
    chk("release hold doa", 8'(doa_v[0]), 8'h01);
    chk("release hold dob", dob_v[0], 8'h5A);
    for (int b = 0; b < 2048; b++) begin
      enb = 1'b1; web = 1'b1; addrb = 11'(b); dib = 8'($urandom);
      tick();
    end
    idle(); enb = 1'b1; web = 1'b1; addrb = 11'h005; dib = 8'hA5;
    tick();
    idle();
    for (int k = 0; k < 8; k++) begin
      ena = 1'b1; addra = 14'(40 + k);
      tick();
      chk($sformatf("map bit %0d", k), 8'(doa_v[0]), 8'(pat[k]));
    end
    idle(); enb = 1'b1; web = 1'b1; addrb = 11'h000; dib = 8'h00;
    tick();
    idle(); ena = 1'b1; addra = 14'd40;
    tick();
    idle();
    tick();
    ena = 1'b1; wea = 1'b1; addra = 14'd3; dia = 1'b1;
    tick();
    chk("mode WRITE_FIRST", 8'(doa_v[0]), 8'h01);
    chk("mode READ_FIRST", 8'(doa_v[1]), 8'h00);
    idle();
    tick();
    chk("mode NO_CHANGE", 8'(doa_v[2]), 8'h01);
    ena = 1'b1; addra = 14'd3;
    tick();
    chk("readback WF", 8'(doa_v[0]), 8'h01);
    chk("readback RF", 8'(doa_v[1]), 8'h01);
    idle();
    tick();
    chk("readback NC", 8'(doa_v[2]), 8'h01);
    coll_clr = 1'b1;
    tick();
    idle(); ena = 1'b1; wea = 1'b1; addra = 14'd41; dia = 1'b1; enb = 1'b1; web = 1'b1; addrb = 11'h005; dib = 8'h00;
    tick();
    chk("ww coll", 8'(coll_v[0]), 8'h01);
    idle(); enb = 1'b1; addrb = 11'h005;
    tick();
    chk("ww B wins", dob_v[0], 8'h00);
    idle(); coll_clr = 1'b1;
    tick();
    chk("coll clear", 8'(coll_v[0]), 8'h00);
    ena = 1'b1; wea = 1'b1; addra = 14'd41; dia = 1'b1; enb = 1'b1; web = 1'b1; addrb = 11'h005; dib = 8'h00;
    tick();
    chk("set beats clear", 8'(coll_v[0]), 8'h01);
    idle(); coll_clr = 1'b1;
    tick();
    idle(); ena = 1'b1; addra = 14'd41; enb = 1'b1; web = 1'b1; addrb = 11'h005; dib = 8'hFF;
    tick();
    chk("rw coll", 8'(coll_v[0]), 8'h02);
    chk("rw old data", 8'(doa_v[0]), 8'h00);
    idle(); ena = 1'b1; addra = 14'd41;
    tick();
    chk("rw new data", 8'(doa_v[0]), 8'h01);
    idle(); enb = 1'b1; web = 1'b1; ssrb = 1'b1; addrb = 11'h007; dib = 8'h3C;
    tick();
    chk("ssr srval", dob_v[0], 8'h81);
    chk("ssr srval u2", dob_v[2], 8'h7E);
    idle(); enb = 1'b1; addrb = 11'h007;
    tick();
    chk("ssr wrote", dob_v[0], 8'h3C);
    idle(); enb = 1'b1; addrb = 11'h005;
    tick();
    chk("doreg edge1", dob_v[1], 8'h3C);
    idle();
    tick();
    chk("doreg edge2", dob_v[1], 8'hFF);
    enb = 1'b1; addrb = 11'h007; regceb = 1'b0;
    tick();
    chk("regce hold 1", dob_v[1], 8'hFF);
    idle(); regceb = 1'b0;
    tick();
    chk("regce hold 2", dob_v[1], 8'hFF);
    idle();
    tick();
    chk("regce load", dob_v[1], 8'h3C);
    ssrb = 1'b1;
    tick();
    chk("doreg ssr", dob_v[1], 8'h81);
    idle(); ena = 1'b1; addra = 14'd40; enb = 1'b1; addrb = 11'h007;
    model_step();
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    idle();
    @(negedge clk);
    chk("midreset doa", 8'(doa_v[0]), 8'h01);
    chk("midreset dob", dob_v[0], 8'h5A);
    chk("midreset dob u1", dob_v[1], 8'hC3);
    chk("midreset coll", 8'(coll_v[0]), 8'h00);
    enb = 1'b1; web = 1'b1; addrb = 11'h006; dib = 8'h99;
    rst_n = 1'b1;
    tick();
    idle(); enb = 1'b1; addrb = 11'h006;
    tick();
    chk("post reset write", dob_v[0], 8'h99);
    for (int n = 0; n < 3000; n++) begin
      ena = ($urandom_range(0, 3) != 0);
      wea = 1'($urandom_range(0, 1));
      ssra = ($urandom_range(0, 9) == 0);
      regcea = ($urandom_range(0, 3) != 0);
      addra = 14'($urandom_range(0, 39));
      dia = 1'($urandom);
      enb = ($urandom_range(0, 3) != 0);
      web = 1'($urandom_range(0, 1));
      ssrb = ($urandom_range(0, 9) == 0);
      regceb = ($urandom_range(0, 3) != 0);
      addrb = 11'($urandom_range(0, 4));
      dib = 8'($urandom);
      coll_clr = ($urandom_range(0, 9) == 0);
      tick();
    end
    idle();
    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
